ifetch_axi: RTL and testbench

IFETCH_AXI -- requirements
Module: ifetch_axi

---
 rtl/ifetch_pkg.sv | 36 +++
 rtl/ifetch_axi.sv | 182 ++++++++++++++++++
 tb/tb_ifetch_axi.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
//   Shared definitions for the AXI-Lite instruction fetch unit.
//   - state_e       : fetch FSM state encoding (ST_ERR only exists when
//                     IFETCH_RESP_CHECK_EN is defined)
//   - AXI_RESP_OKAY : the only AXI read response treated as success
//   - ADDR_SHIFT    : word-to-byte shift applied to the PC (4-byte slots)
//   - resp_is_error : helper classifying an AXI read response
// ----------------------------------------------------------------------------
package ifetch_pkg;

`ifdef IFETCH_RESP_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_ERR
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } state_e;
`endif

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         ADDR_SHIFT    = 2;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifetch_axi.sv
// ----------------------------------------------------------------------------
// ifetch_axi
//   Single-outstanding AXI-Lite instruction fetch unit. Issues one read per
//   instruction at byte address {pc_in, 2'b00}, holds the returned word for
//   the decoder, and pulses pc_en when decode accepts it. A flush discards
//   whatever fetch is in flight or held; an AR request already presented is
//   still completed and its R beat consumed, so the bus never sees a
//   withdrawn request.
//
//   Parameters
//     PC_W     program-counter width
//     INSTR_W  instruction width (= AXI read-data width)
//     ADDR_W   AXI address width, must be >= PC_W + 2
//
//   Ports
//     clk, rst            rising-edge clock, synchronous active-high reset
//     run                 allow new fetches to start
//     flush               discard in-flight / held fetch (branch redirect)
//     pc_in               PC to fetch from
//     pc_en               one-cycle PC-advance pulse
//     m_ar*, m_r*         AXI-Lite read address / read data channels
//     instr_out/valid     fetched instruction to decode
//     instr_ready         decode accepts instr_out
//     fetch_err           sticky fetch error
//
//   Configuration
//     IFETCH_RESP_CHECK_EN  when defined, a non-OKAY response on a beat that
//                           is not being dropped sets fetch_err and parks the
//                           unit in ST_ERR until reset. When undefined,
//                           m_rresp is ignored and fetch_err is tied low.
// ----------------------------------------------------------------------------
module ifetch_axi
  import ifetch_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc_in,
  output logic               pc_en,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [INSTR_W-1:0] m_rdata,
  input  logic [1:0]         m_rresp,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_err
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    araddr_q, araddr_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  // Set when a flush hits an outstanding fetch; the R beat is then discarded.
  logic                 drop_q, drop_d;
`ifdef IFETCH_RESP_CHECK_EN
  logic                 err_q, err_d;
`endif

  // NOTE: every register here is a few bits wide, so all of them take the
  // reset value; nothing is left uninitialised after reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      instr_q  <= '0;
      drop_q   <= 1'b0;
`ifdef IFETCH_RESP_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      instr_q  <= instr_d;
      drop_q   <= drop_d;
`ifdef IFETCH_RESP_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every *_d and no latch
    // is inferred.
    state_d  = state_q;
    araddr_d = araddr_q;
    instr_d  = instr_q;
    drop_d   = drop_q;
`ifdef IFETCH_RESP_CHECK_EN
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run && !flush) begin
          araddr_d = ADDR_W'(pc_in) << ADDR_SHIFT;
          drop_d   = 1'b0;
          state_d  = ST_ADDR;
        end
      end

      // arvalid must stay up until the handshake; flush only marks the
      // fetch for discarding.
      ST_ADDR: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (m_arready) begin
          state_d = ST_DATA;
        end
      end

      // A flush arriving in the same cycle as the beat drops it too.
      ST_DATA: begin
        if (m_rvalid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = ST_IDLE;
          end
`ifdef IFETCH_RESP_CHECK_EN
          else if (resp_is_error(m_rresp)) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
`endif
          else begin
            instr_d = m_rdata;
            state_d = ST_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      // Flush wins over a simultaneous instr_ready.
      ST_HOLD: begin
        if (flush || instr_ready) begin
          state_d = ST_IDLE;
        end
      end

`ifdef IFETCH_RESP_CHECK_EN
      ST_ERR: begin
        state_d = ST_ERR;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded straight from the state register.
  assign m_arvalid   = (state_q == ST_ADDR);
  assign m_rready    = (state_q == ST_DATA);
  assign instr_valid = (state_q == ST_HOLD);
  assign m_araddr    = araddr_q;
  assign instr_out   = instr_q;

  // pc_en is the HOLD-state handshake itself, so it exists only in that cycle.
  assign pc_en = (state_q == ST_HOLD) && instr_ready && !flush && !rst;

`ifdef IFETCH_RESP_CHECK_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
  // The response code has no effect in this build.
  logic rresp_unused;
  assign rresp_unused = ^m_rresp;
`endif

endmodule

// File: tb/tb_ifetch_axi.sv
// ----------------------------------------------------------------------------
// tb_ifetch_axi
//   Self-checking bench for ifetch_axi. A behavioural model tracks the single
//   fetch in progress as a record (launched / address accepted / data
//   received / marked for discard) and derives every expected output from
//   it; a compare process checks all outputs on each falling edge. Directed
//   scenarios with literal expectations come first, then a randomized run.
// ----------------------------------------------------------------------------
module tb_ifetch_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  pc_in = '0;
  logic        pc_en;
  logic [7:0]  m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [15:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_err;

  ifetch_axi #(.PC_W(4), .INSTR_W(16), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .flush       (flush),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit live;     // a fetch has been launched and not yet retired
    bit ar_done;  // its address was accepted
    bit r_done;   // its data arrived and is being offered to decode
    bit drop;     // a flush hit it; its data will be thrown away
  } fetch_t;

  fetch_t      f       = '0;
  logic [7:0]  exp_addr  = '0;
  logic [15:0] exp_instr = '0;
  bit          dead      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      f         = '0;
      exp_addr  = '0;
      exp_instr = '0;
      dead      = 1'b0;
    end else if (dead) begin
      f = '0;
    end else if (!f.live) begin
      if (run && !flush) begin
        f        = '0;
        f.live   = 1'b1;
        exp_addr = 8'(pc_in) * 8'd4;
      end
    end else if (!f.ar_done) begin
      if (flush) f.drop = 1'b1;
      if (m_arready) f.ar_done = 1'b1;
    end else if (!f.r_done) begin
      if (m_rvalid) begin
        if (f.drop || flush) begin
          f = '0;
        end
`ifdef IFETCH_RESP_CHECK_EN
        else if (m_rresp != 2'b00) begin
          f    = '0;
          dead = 1'b1;
        end
`endif
        else begin
          f.r_done  = 1'b1;
          exp_instr = m_rdata;
        end
      end else if (flush) begin
        f.drop = 1'b1;
      end
    end else begin
      if (flush || instr_ready) f = '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("arvalid",     32'(m_arvalid),   32'(f.live && !f.ar_done));
      check("araddr",      32'(m_araddr),    32'(exp_addr));
      check("rready",      32'(m_rready),    32'(f.live && f.ar_done && !f.r_done));
      check("instr_valid", 32'(instr_valid), 32'(f.live && f.r_done));
      check("instr_out",   32'(instr_out),   32'(exp_instr));
      check("pc_en",       32'(pc_en),       32'(f.live && f.r_done && instr_ready && !flush && !rst));
      check("fetch_err",   32'(fetch_err),   32'(dead));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_arvalid"},     32'(m_arvalid),   32'd0);
    check({tag, "_rready"},      32'(m_rready),    32'd0);
    check({tag, "_araddr"},      32'(m_araddr),    32'd0);
    check({tag, "_instr_out"},   32'(instr_out),   32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc_en"},       32'(pc_en),       32'd0);
    check({tag, "_fetch_err"},   32'(fetch_err),   32'd0);
  endtask

  initial begin
    // ---- reset ----
    tick();
    tick();
    cmp_en = 1'b1;
    check_reset_values("rst0");

    // ---- basic fetch at minimum latency ----
    rst = 1'b0; pc_in = 4'd3; run = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1;
    m_rdata = 16'hA5A5; instr_ready = 1'b1;
    tick();
    check("basic_arvalid", 32'(m_arvalid), 32'd1);
    check("basic_araddr",  32'(m_araddr),  32'h0C);
    check("model_araddr",  32'(exp_addr),  32'h0C);
    tick();
    check("basic_rready",  32'(m_rready),  32'd1);
    check("basic_nvalid",  32'(instr_valid), 32'd0);
    tick();
    check("basic_valid_c3", 32'(instr_valid), 32'd1);
    check("basic_instr",    32'(instr_out),   32'hA5A5);
    check("basic_pc_en",    32'(pc_en),       32'd1);
    check("model_instr",    32'(exp_instr),   32'hA5A5);
    run = 1'b0;
    tick();
    check("basic_after_valid", 32'(instr_valid), 32'd0);
    check("basic_after_pc_en", 32'(pc_en),       32'd0);

    // ---- flush while AR stalled ----
    pc_in = 4'd5; run = 1'b1; m_arready = 1'b0; m_rvalid = 1'b0; instr_ready = 1'b0;
    tick();
    flush = 1'b1; run = 1'b0;
    tick();
    flush = 1'b0;
    check("flushar_arvalid_c2", 32'(m_arvalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flushar_arvalid_hold", 32'(m_arvalid), 32'd1);
      check("flushar_araddr",       32'(m_araddr),  32'h14);
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 16'h1234;
    check("flushar_rready", 32'(m_rready), 32'd1);
    tick();
    check("flushar_no_valid",  32'(instr_valid), 32'd0);
    check("flushar_no_rready", 32'(m_rready),    32'd0);
    check("flushar_instr_kept", 32'(instr_out),  32'hA5A5);
    check("flushar_pc_en",     32'(pc_en),       32'd0);
    m_rvalid = 1'b0;

    // ---- decode back-pressure in HOLD ----
    pc_in = 4'd7; run = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 16'hBEEF;
    tick(); tick(); tick();
    run = 1'b0; m_rdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", 32'(instr_out),   32'hBEEF);
      check("hold_pc_en", 32'(pc_en),       32'd0);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    check("hold_accept_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("hold_idle_valid", 32'(instr_valid), 32'd0);
    check("hold_idle_pc_en", 32'(pc_en),       32'd0);
    instr_ready = 1'b0;

    // ---- flush and accept in the same HOLD cycle ----
    pc_in = 4'd2; run = 1'b1; m_rdata = 16'hCAFE;
    tick(); tick(); tick();
    run = 1'b0;
    check("hflush_valid", 32'(instr_valid), 32'd1);
    flush = 1'b1; instr_ready = 1'b1;
    #1;
    check("hflush_pc_en", 32'(pc_en), 32'd0);
    tick();
    check("hflush_valid_next", 32'(instr_valid), 32'd0);
    flush = 1'b0; instr_ready = 1'b0;

    // ---- reset while waiting for data ----
    pc_in = 4'd9; run = 1'b1; m_arready = 1'b1; m_rvalid = 1'b0;
    tick(); tick();
    check("rstdata_rready", 32'(m_rready), 32'd1);
    rst = 1'b1; pc_in = 4'd0;
    tick();
    check_reset_values("rst1");
    rst = 1'b0;
    tick();
    check("rst1_refetch_arvalid", 32'(m_arvalid), 32'd1);
    check("rst1_refetch_araddr",  32'(m_araddr),  32'h00);
    m_rvalid = 1'b1; m_rdata = 16'h0F0F; instr_ready = 1'b1;
    tick(); tick();
    check("rst1_refetch_instr", 32'(instr_out), 32'h0F0F);
    run = 1'b0;
    tick();
    instr_ready = 1'b0;

    // ---- error response ----
    pc_in = 4'd4; run = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1;
    m_rresp = 2'b10; m_rdata = 16'hDEAD;
    tick(); tick(); tick();
`ifdef IFETCH_RESP_CHECK_EN
    check("err_flag",  32'(fetch_err),   32'd1);
    check("err_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_arvalid", 32'(m_arvalid), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", 32'(fetch_err), 32'd0);
`else
    check("noerr_valid", 32'(instr_valid), 32'd1);
    check("noerr_instr", 32'(instr_out),   32'hDEAD);
    check("noerr_flag",  32'(fetch_err),   32'd0);
    run = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
`endif
    m_rresp = 2'b00;

    // ---- randomized run ----
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      run         = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      pc_in       = 4'($urandom_range(0, 15));
      m_arready   = 1'($urandom_range(0, 1));
      m_rvalid    = 1'($urandom_range(0, 1));
      m_rdata     = 16'($urandom);
      m_rresp     = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end

    rst = 1'b0; run = 1'b0; flush = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
